pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stall_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline
//               (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Merges ID-stage stall
//               requests with counted multi-cycle EX operations (div,
//               madd/msub) and applies flush with top priority.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of ex_cycles and of the internal busy counter
//   PERF_W       width of the stall_cycles performance counter
// Optional feature macro
//   STALL_PERF_EN  when defined, stall_cycles counts cycles with stall[0]=1
//                  (saturating, cleared by rst); otherwise tied to zero
// Ports
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   stallreq_id   in   ID stage load-use/operand stall request
//   ex_start      in   EX begins a multi-cycle op this cycle
//   ex_cycles     in   stall cycles the op needs (sampled on accepted start)
//   flush_req     in   exception/redirect from MEM, kills in-flight work
//   stall         out  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM-in [4]MEM/WB [5]WB
//   flush         out  clear all pipeline registers this cycle
//   ex_busy       out  EX multi-cycle op in progress (BUSY or accepted start)
//   ex_done       out  registered one-cycle pulse, EX result valid
//   stall_cycles  out  saturating count of cycles with stall[0]=1
// ============================================================================
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_start,
  input  logic [CNT_W-1:0]  ex_cycles,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              ex_busy,
  output logic              ex_done,
  output logic [PERF_W-1:0] stall_cycles
);

  // Stall vectors are always thermometer coded. The lowest held stage
  // boundary decides where the bubble is inserted:
  //   ID stall -> ID/EX loads a bubble, EX keeps running
  //   EX stall -> EX/MEM loads a bubble, ID/EX and upstream hold
  localparam logic [5:0] C_STALL_NONE = 6'b000000;
  localparam logic [5:0] C_STALL_ID   = 6'b000111;
  localparam logic [5:0] C_STALL_EX   = 6'b001111;

  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_ex_done;

  logic [5:0]       w_stall;
  logic             w_flush;
  logic             w_ex_busy;
  logic             w_start_ok;

  // A zero-length op needs no stall at all, so it is simply not accepted.
  assign w_start_ok = ex_start && (ex_cycles != C_CNT_ZERO);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= C_CNT_ZERO;
      r_ex_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      // ex_done mirrors "FSM is in DONE" but comes straight from a flop.
      r_ex_done <= (w_state_next == S_DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = C_STALL_NONE;
    w_flush      = 1'b0;
    w_ex_busy    = 1'b0;

    if (flush_req) begin
      // Flush overrides everything: no hold, abort any op in progress.
      w_flush      = 1'b1;
      w_state_next = S_IDLE;
      w_cnt_next   = C_CNT_ZERO;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            // The start cycle itself is the first stalled cycle.
            w_stall   = C_STALL_EX;
            w_ex_busy = 1'b1;
            if (ex_cycles == C_CNT_ONE) begin
              w_state_next = S_DONE;
              w_cnt_next   = C_CNT_ZERO;
            end else begin
              w_state_next = S_BUSY;
              w_cnt_next   = ex_cycles - C_CNT_ONE;
            end
          end else if (stallreq_id) begin
            w_stall = C_STALL_ID;
          end
        end

        S_BUSY: begin
          // EX stall dominates any concurrent ID request.
          w_stall   = C_STALL_EX;
          w_ex_busy = 1'b1;
          // "<=" rather than "==" so a corrupted zero count cannot wrap.
          if (r_cnt <= C_CNT_ONE) begin
            w_state_next = S_DONE;
            w_cnt_next   = C_CNT_ZERO;
          end else begin
            w_cnt_next = r_cnt - C_CNT_ONE;
          end
        end

        S_DONE: begin
          // Result leaves EX now; ex_start still refers to the finishing
          // instruction and must not restart the op.
          w_state_next = S_IDLE;
          if (stallreq_id) begin
            w_stall = C_STALL_ID;
          end
        end

        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = C_CNT_ZERO;
        end
      endcase
    end
  end

  // Combinational outputs are forced quiet while reset is asserted.
  assign stall   = rst ? C_STALL_NONE : w_stall;
  assign flush   = rst ? 1'b0         : w_flush;
  assign ex_busy = rst ? 1'b0         : w_ex_busy;
  assign ex_done = r_ex_done;

  // --------------------------------------------------------------------------
  // Optional stall performance counter
  // --------------------------------------------------------------------------
`ifdef STALL_PERF_EN
  localparam logic [PERF_W-1:0] C_PERF_ONE = PERF_W'(1);

  logic [PERF_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall[0] && (r_stall_cycles != {PERF_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + C_PERF_ONE;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl. Each step
//               drives inputs, pushes the expected outputs onto a scoreboard
//               queue and pops/compares them once outputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  localparam int CNT_W  = 6;
  localparam int PERF_W = 3;   // small so saturation is reachable

  logic              clk;
  logic              rst;
  logic              stallreq_id;
  logic              ex_start;
  logic [CNT_W-1:0]  ex_cycles;
  logic              flush_req;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_busy;
  logic              ex_done;
  logic [PERF_W-1:0] stall_cycles;

  typedef struct {
    string      tag;
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_start     (ex_start),
    .ex_cycles    (ex_cycles),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .ex_busy      (ex_busy),
    .ex_done      (ex_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs after the falling edge, then check outputs
  // before the next rising edge.
  task automatic step(input string tag, input logic r, input logic sid,
                      input logic st, input int cyc, input logic fr,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic e_busy, input logic e_done);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst         = r;
    stallreq_id = sid;
    ex_start    = st;
    ex_cycles   = CNT_W'(cyc);
    flush_req   = fr;
    e.tag = tag; e.stall = e_stall; e.flush = e_flush;
    e.busy = e_busy; e.done = e_done;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    n_assert++;
    assert (stall === g.stall) else begin
      n_fail++;
      $error("FAIL %s stall got %b expected %b", g.tag, stall, g.stall);
    end
    n_assert++;
    assert (flush === g.flush) else begin
      n_fail++;
      $error("FAIL %s flush got %b expected %b", g.tag, flush, g.flush);
    end
    n_assert++;
    assert (ex_busy === g.busy) else begin
      n_fail++;
      $error("FAIL %s ex_busy got %b expected %b", g.tag, ex_busy, g.busy);
    end
    n_assert++;
    assert (ex_done === g.done) else begin
      n_fail++;
      $error("FAIL %s ex_done got %b expected %b", g.tag, ex_done, g.done);
    end
  endtask

  // Counter check; without the feature the port must read zero.
  task automatic check_perf(input string tag, input int cnt_if_enabled);
    logic [PERF_W-1:0] e;
`ifdef STALL_PERF_EN
    e = PERF_W'(cnt_if_enabled);
`else
    e = '0;
    if (cnt_if_enabled < 0) e = '1;
`endif
    n_assert++;
    assert (stall_cycles === e) else begin
      n_fail++;
      $error("FAIL %s stall_cycles got %0d expected %0d", tag, stall_cycles, e);
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0;
    ex_cycles = '0; flush_req = 1'b0;

    // 1: reset with every input high
    step("rst_a", 1, 1, 1, 63, 1, 6'b000000, 0, 0, 0);
    step("rst_b", 1, 1, 1, 63, 1, 6'b000000, 0, 0, 0);
    check_perf("perf_rst", 0);
    step("idle",  0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // 2: ID stall for two cycles
    step("id_0",  0, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
    step("id_1",  0, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
    step("id_end",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // 3: three-cycle op; ID request in BUSY is dominated, start in DONE ignored
    step("ex3_T0",0, 0, 1, 3, 0, 6'b001111, 0, 1, 0);
    step("ex3_T1",0, 1, 0, 0, 0, 6'b001111, 0, 1, 0);
    step("ex3_T2",0, 0, 0, 0, 0, 6'b001111, 0, 1, 0);
    step("ex3_T3",0, 0, 1, 3, 0, 6'b000000, 0, 0, 1);
    step("ex3_T4",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    check_perf("perf_five", 5);

    // 4: one-cycle op, then zero-length op ignored
    step("ex1_T0",0, 0, 1, 1, 0, 6'b001111, 0, 1, 0);
    step("ex1_T1",0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    step("ex1_T2",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("ex0_T0",0, 0, 1, 0, 0, 6'b000000, 0, 0, 0);
    step("ex0_T1",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    check_perf("perf_six", 6);

    // 5: ten-cycle op aborted by flush at T+4
    step("ex10_T0",0, 0, 1, 10, 0, 6'b001111, 0, 1, 0);
    for (int i = 1; i < 4; i++)
      step("ex10_busy", 0, 0, 0, 0, 0, 6'b001111, 0, 1, 0);
    step("ex10_fl",0, 1, 1, 5, 1, 6'b000000, 1, 0, 0);
    step("ex10_T5",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("ex10_T6",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    check_perf("perf_sat", 7);

    // start together with ID request: EX wins and the start is accepted
    step("both_T0",0, 1, 1, 2, 0, 6'b001111, 0, 1, 0);
    step("both_T1",0, 0, 0, 0, 0, 6'b001111, 0, 1, 0);
    step("both_T2",0, 1, 0, 0, 0, 6'b000111, 0, 0, 1);
    step("both_T3",0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    check_perf("perf_hold", 7);

    // reset in the middle of an op
    step("mr_T0", 0, 0, 1, 5, 0, 6'b001111, 0, 1, 0);
    step("mr_rst",1, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("mr_T2", 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    check_perf("perf_clr", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
